// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiplier / restoring divider driving the HI and LO registers.
// Define MULT_FAST_EN to finish MULT/MULTU in one cycle on a combinational 2*WIDTH multiplier.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             isDiv_q, isDiv_d;
   logic             negRes_q, negRes_d;
   logic             negRem_q, negRem_d;
   logic             bZero_q, bZero_d;
   logic [WIDTH-1:0] aRaw_q, aRaw_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] accHi_q, accHi_d;
   logic [WIDTH-1:0] accLo_q, accLo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             divZero_q, divZero_d;

   logic             signedOp, aNeg, bNeg;
   logic [WIDTH-1:0] aMag, bMag;

   logic [WIDTH:0]     mulSum, remShift, divDiff;
   logic               divFits;
   logic [WIDTH-1:0]   stepHi, stepLo;
   logic [2*WIDTH-1:0] prodMag, prodRes;
   logic [WIDTH-1:0]   quoRes, remRes;

   // Signed ops iterate on magnitudes; the result signs are captured at launch.
   always_comb begin
      signedOp = ~op[0];
      aNeg     = signedOp & A[WIDTH-1];
      bNeg     = signedOp & B[WIDTH-1];
      aMag     = aNeg ? -A : A;
      bMag     = bNeg ? -B : B;
   end

   // One iteration: multiply keeps {carry,HI,LO} shifting right, divide keeps {rem,quo} shifting left.
   always_comb begin
      mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opnd_q} : '0);
      remShift = {accHi_q, accLo_q[WIDTH-1]};
      divDiff  = remShift - {1'b0, opnd_q};
      divFits  = ~divDiff[WIDTH];
      if (isDiv_q) begin
         stepHi = divFits ? divDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
         stepLo = {accLo_q[WIDTH-2:0], divFits};
      end else begin
         stepHi = mulSum[WIDTH:1];
         stepLo = {mulSum[0], accLo_q[WIDTH-1:1]};
      end
      prodMag = {stepHi, stepLo};
      prodRes = negRes_q ? -prodMag : prodMag;
      quoRes  = negRes_q ? -stepLo : stepLo;
      remRes  = negRem_q ? -stepHi : stepHi;
   end

`ifdef MULT_FAST_EN
   logic [2*WIDTH-1:0] fastA, fastB, fastProd;

   always_comb begin
      fastA    = op[0] ? {{WIDTH{1'b0}}, A} : {{WIDTH{A[WIDTH-1]}}, A};
      fastB    = op[0] ? {{WIDTH{1'b0}}, B} : {{WIDTH{B[WIDTH-1]}}, B};
      fastProd = fastA * fastB;
   end
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      isDiv_d   = isDiv_q;
      negRes_d  = negRes_q;
      negRem_d  = negRem_q;
      bZero_d   = bZero_q;
      aRaw_d    = aRaw_q;
      opnd_d    = opnd_q;
      accHi_d   = accHi_q;
      accLo_d   = accLo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      divZero_d = 1'b0;

      case (state_q)
         IDLE, FIN: begin
            if (start) begin
               state_d  = RUN;
               cnt_d    = '0;
               isDiv_d  = op[1];
               negRes_d = aNeg ^ bNeg;
               negRem_d = aNeg;
               bZero_d  = (B == '0);
               aRaw_d   = A;
               opnd_d   = op[1] ? bMag : aMag;
               accHi_d  = '0;
               accLo_d  = op[1] ? aMag : bMag;
`ifdef MULT_FAST_EN
               if (!op[1]) begin
                  state_d = FIN;
                  hi_d    = fastProd[2*WIDTH-1:WIDTH];
                  lo_d    = fastProd[WIDTH-1:0];
               end
`endif
            end else begin
               state_d = IDLE;
            end
         end

         RUN: begin
            accHi_d = stepHi;
            accLo_d = stepLo;
            cnt_d   = cnt_q + CW'(1);
            // HI/LO change only on the edge into FIN, from the final iteration's values.
            if (cnt_q == LAST) begin
               state_d = FIN;
               if (!isDiv_q) begin
                  hi_d = prodRes[2*WIDTH-1:WIDTH];
                  lo_d = prodRes[WIDTH-1:0];
               end else if (bZero_q) begin
                  hi_d      = aRaw_q;
                  lo_d      = '1;
                  divZero_d = 1'b1;
               end else begin
                  hi_d = remRes;
                  lo_d = quoRes;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         isDiv_q   <= 1'b0;
         negRes_q  <= 1'b0;
         negRem_q  <= 1'b0;
         bZero_q   <= 1'b0;
         aRaw_q    <= '0;
         opnd_q    <= '0;
         accHi_q   <= '0;
         accLo_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         divZero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         isDiv_q   <= isDiv_d;
         negRes_q  <= negRes_d;
         negRem_q  <= negRem_d;
         bZero_q   <= bZero_d;
         aRaw_q    <= aRaw_d;
         opnd_q    <= opnd_d;
         accHi_q   <= accHi_d;
         accLo_q   <= accLo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         divZero_q <= divZero_d;
      end
   end

   assign busy     = (state_q == RUN);
   assign done     = (state_q == FIN);
   assign div_zero = divZero_q;
   assign hi_out   = hi_q;
   assign lo_out   = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit for the multicycle datapath. It produces the HI and LO registers that feed the write-back data-select stage, which routes them into the register file. The control FSM starts an operation with a one-cycle `start` pulse and stalls on `busy` until `done` pulses. HI and LO then hold their values until the next completed operation.

## Interface
- `WIDTH`, 32, operand width; HI/LO are each WIDTH bits; iteration count = WIDTH
- `clk` input 1 — rising-edge clock
- `reset` input 1 — asynchronous, active-low reset
- `start` input 1 — launch request, sampled on rising edge
- `op` input 2 — operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- `A` input WIDTH — multiplicand / dividend
- `B` input WIDTH — multiplier / divisor
- `busy` output 1 — operation in progress
- `done` output 1 — one-cycle completion pulse
- `div_zero` output 1 — divide by zero; valid with `done`
- `hi_out` output WIDTH — HI register (product upper half / remainder)
- `lo_out` output WIDTH — LO register (product lower half / quotient)

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: iterating; `busy`=1.
  - FIN: one cycle; `done`=1, HI/LO written.
- Transitions:
  - IDLE/FIN with `start`=1 → RUN. The same edge latches `op`, A and B, and clears the iteration counter.
  - RUN with counter = WIDTH-1 → FIN.
  - FIN without `start` → IDLE.
- `start` while in RUN is ignored. No queueing; operands and `op` are not re-sampled.
- Signed operations:
  - Iterate on operand magnitudes and record the result signs at launch.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
- Multiply:
  - Shift-add, one multiplier bit per cycle.
  - Result is the full 2·WIDTH two's-complement product; HI = upper half, LO = lower half.
- Divide:
  - Restoring, one quotient bit per cycle.
  - LO = quotient, HI = remainder (truncating toward zero).
- Divide by zero (B = 0):
  - Full latency still applies.
  - Result: LO = all ones, HI = A (raw dividend, unsigned and signed), `div_zero`=1 during FIN.
- Signed overflow (A = most-negative, B = -1): LO = most-negative value, HI = 0, `div_zero`=0.
- HI/LO hold their value except on FIN. They are never partially updated while `busy`.
- Reset while asserted, at any time (including mid-RUN):
  - State returns to IDLE immediately.
  - `busy`, `done`, `div_zero` go to 0; HI/LO are cleared.
  - No `done` is produced for the aborted operation.

## Timing
- Reset values: `busy`=0, `done`=0, `div_zero`=0, `hi_out`=0, `lo_out`=0, state IDLE.
- All outputs are registered; none are combinational from inputs.
- `start` sampled high at edge 0:
  - `busy`=1 from after edge 0 through the last RUN cycle (WIDTH cycles).
  - FIN is entered after edge WIDTH: `done`=1, `busy`=0, and new HI/LO are visible in that same cycle.
- Latency is start edge → `done` high = WIDTH+1 cycles, i.e. 33 for WIDTH=32. This holds for every `op` in the default build.
- Back-to-back operation: `start` during FIN is accepted. `done` drops and `busy` rises on the next edge, so there is zero bubble cycles.
- `div_zero` is 0 whenever `done` is 0.

## Configuration
- `MULT_FAST_EN` defined:
  - MULT/MULTU bypass iteration: `start` edge → FIN directly, so `done` is high one cycle after `start`.
  - Product is computed by a single-cycle 2·WIDTH multiplier.
  - `busy` never asserts for multiplies.
  - Divide behaviour is unchanged (WIDTH+1 latency).
- `MULT_FAST_EN` undefined: all operations iterate as specified above (WIDTH+1 latency).

## Test plan
- Reset mid-operation: assert `reset`=0 during cycle 10 of a DIVU → HI=LO=0, `busy`=0, no `done` pulse after release. A following MULTU 3×5 returns LO=15, HI=0.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001, `done` exactly 33 cycles after `start` (1 cycle with `MULT_FAST_EN`).
- MULT A=-7 (0xFFFFFFF9), B=6 → HI=0xFFFFFFFF, LO=0xFFFFFFD6 (-42); `busy` high for 32 cycles.
- DIV A=-7, B=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=100, B=7 → LO=14, HI=2.
- DIVU A=0x1234, B=0 → LO=0xFFFFFFFF, HI=0x1234, `div_zero`=1 only in the `done` cycle. DIV A=0x80000000, B=-1 → LO=0x80000000, HI=0, `div_zero`=0.
- `start` pulses in RUN ignored (result matches the first operands). `start` in the FIN cycle launches immediately: the second `done` arrives 33 cycles after the first.
